call_stack_ctrl: RTL

CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

---
 rtl/call_stack_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack for a jump-with-link controller.
// Tracks depth with a count register, flags over/underflow, and freezes in FAULT until clrErr.
module call_stack_ctrl #(
    parameter int AW    = 13,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            pushAddr,
    input  logic                     clrErr,
    output logic [AW-1:0]            topAddr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     fault
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
    logic [AW-1:0] r_mem [DEPTH];

    logic          w_wr_en;
    logic [IW-1:0] w_wr_idx;
    logic [CW-1:0] w_count_m1;
    logic [IW-1:0] w_top_idx;

    assign w_count_m1 = r_count - ONE;
    assign w_top_idx  = w_count_m1[IW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_count[IW-1:0];

        if (clrErr) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_unf_nxt   = 1'b0;
        end else if (r_state == ST_RUN) begin
            if (push && pop) begin
                // Simultaneous call and return replaces the top entry in place.
                if (r_count != '0) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = w_top_idx;
                end else begin
                    w_unf_nxt   = 1'b1;
                    w_state_nxt = ST_FAULT;
                end
            end else if (push) begin
                if (r_count != FULL_CNT) begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_count + ONE;
                end else begin
                    w_ovf_nxt   = 1'b1;
                    w_state_nxt = ST_FAULT;
                end
            end else if (pop) begin
                if (r_count != '0) begin
                    w_count_nxt = w_count_m1;
                end else begin
                    w_unf_nxt   = 1'b1;
                    w_state_nxt = ST_FAULT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Entry storage is deliberately unreset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (w_wr_en && rst) begin
            r_mem[w_wr_idx] <= pushAddr;
        end
    end

    assign topAddr   = (r_count != '0) ? r_mem[w_top_idx] : '0;
    assign count     = r_count;
    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign fault     = (r_state == ST_FAULT);

endmodule
